// File: rtl/store_buffer_fwd.sv
// Dual-issue store buffer with in-order commit, memory drain and
// two-port youngest-first store-to-load forwarding.
module store_buffer_fwd #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     st_valid1,
   input  logic [ADDR_W-1:0]        st_addr1,
   input  logic [DATA_W-1:0]        st_data1,
   input  logic                     st_valid2,
   input  logic [ADDR_W-1:0]        st_addr2,
   input  logic [DATA_W-1:0]        st_data2,
   input  logic                     ld_valid1,
   input  logic [ADDR_W-1:0]        ld_addr1,
   input  logic                     ld_valid2,
   input  logic [ADDR_W-1:0]        ld_addr2,
   input  logic                     commit1,
   input  logic                     commit2,
   input  logic                     flush,
   input  logic                     mem_wr_ready,
   output logic                     mem_wr_valid,
   output logic [ADDR_W-1:0]        mem_wr_addr,
   output logic [DATA_W-1:0]        mem_wr_data,
   output logic                     ld_done1,
   output logic                     ld_hit1,
   output logic [DATA_W-1:0]        ld_data1,
   output logic                     ld_done2,
   output logic                     ld_hit2,
   output logic [DATA_W-1:0]        ld_data2,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow_err
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] cmt;
   logic [PW-1:0] tail;

   logic [PW-1:0] used;
   logic [PW-1:0] free;
   logic [PW-1:0] spec_n;
   logic [PW-1:0] req;
   logic [PW-1:0] cmt_step;
   logic [PW-1:0] cmt_nx;
   logic [PW-1:0] tail_nx;
   logic [PW-1:0] enq_n;
   logic [IW-1:0] wr1;
   logic [IW-1:0] wr2;
   logic          acc1;
   logic          acc2;
   logic          drop;
   logic          drain;
   logic          hit1;
   logic          hit2;
   logic [DATA_W-1:0] fwd1;
   logic [DATA_W-1:0] fwd2;

   assign used  = tail - head;
   assign free  = PW'(DEPTH) - used;
   assign count = used;
   assign empty = (used == '0);
   assign full  = (free < PW'(2));

   // slot 2 only gets an entry left over after slot 1 took its share
   assign acc1 = st_valid1 && (free != '0);
   assign acc2 = st_valid2 && (free > PW'(acc1));
   assign drop = (st_valid1 && !acc1) || (st_valid2 && !acc2);
   assign enq_n = PW'(acc1) + PW'(acc2);
   assign wr1 = tail[IW-1:0];
   assign wr2 = wr1 + IW'(acc1);

   always_comb begin
      spec_n   = tail - cmt;
      req      = '0;
      if (commit1) req = commit2 ? PW'(2) : PW'(1);
      cmt_step = (req > spec_n) ? spec_n : req;
      cmt_nx   = cmt + cmt_step;
      tail_nx  = flush ? cmt_nx : tail + enq_n;
   end

   assign mem_wr_valid = (head != cmt);
   assign drain        = mem_wr_valid && mem_wr_ready;
   assign mem_wr_addr  = mem_wr_valid ? addr_q[head[IW-1:0]] : '0;
   assign mem_wr_data  = mem_wr_valid ? data_q[head[IW-1:0]] : '0;

   // oldest to youngest, so the last match left standing is the youngest
   always_comb begin
      hit1 = 1'b0;
      fwd1 = '0;
      hit2 = 1'b0;
      fwd2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (PW'(i) < used) begin
            if (addr_q[head[IW-1:0] + IW'(i)] == ld_addr1) begin
               hit1 = 1'b1;
               fwd1 = data_q[head[IW-1:0] + IW'(i)];
            end
            if (addr_q[head[IW-1:0] + IW'(i)] == ld_addr2) begin
               hit2 = 1'b1;
               fwd2 = data_q[head[IW-1:0] + IW'(i)];
            end
         end
      end
      if (acc1 && st_addr1 == ld_addr2) begin
         hit2 = 1'b1;
         fwd2 = st_data1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         if (acc1) begin
            addr_q[wr1] <= st_addr1;
            data_q[wr1] <= st_data1;
         end
         if (acc2) begin
            addr_q[wr2] <= st_addr2;
            data_q[wr2] <= st_data2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head         <= '0;
         cmt          <= '0;
         tail         <= '0;
         overflow_err <= 1'b0;
         ld_done1     <= 1'b0;
         ld_hit1      <= 1'b0;
         ld_data1     <= '0;
         ld_done2     <= 1'b0;
         ld_hit2      <= 1'b0;
         ld_data2     <= '0;
      end else begin
         cmt  <= cmt_nx;
         tail <= tail_nx;
         if (drain) head <= head + PW'(1);
         if (drop) overflow_err <= 1'b1;
         ld_done1 <= ld_valid1 && !flush;
         ld_hit1  <= ld_valid1 && !flush && hit1;
         ld_data1 <= (ld_valid1 && !flush && hit1) ? fwd1 : '0;
         ld_done2 <= ld_valid2 && !flush;
         ld_hit2  <= ld_valid2 && !flush && hit2;
         ld_data2 <= (ld_valid2 && !flush && hit2) ? fwd2 : '0;
      end
   end

endmodule
